// File: rtl/smc_cfreg_bank_if.sv
// Register-bank access bus between the AHB slave decode and the SMC config bank.
interface smc_cfreg_bank_if #(
  parameter int ADDR_W = 4
);
  logic              sel;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;

  modport master (output sel, wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input sel, wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/smc_cfreg_bank.sv
// SMC configuration register bank: RO ID word, CTRL/status, and double-buffered
// per-chip-select timing registers whose shadow->active transfer waits for smc_idle.
module smc_cfreg_bank #(
  parameter int          N_CS     = 1,
  parameter int          ADDR_W   = 4,
  parameter logic [31:0] CS_RESET = 32'h0000_0101
) (
  input  logic               hclk,
  input  logic               n_sys_reset,
  smc_cfreg_bank_if.slave    bus,
  input  logic               smc_idle,
  output logic [N_CS*32-1:0] cs_config,
  output logic               cfg_update,
  output logic               err_irq
);

  localparam logic [31:0] SMC_CONFIG = {2'b11, 22'b0, 8'(N_CS)};

  typedef enum logic {IDLE, PENDING} apply_state_t;

  apply_state_t state;
  logic         lock;
  logic         err;
  logic [31:0]  shadow [N_CS];
  logic [31:0]  active [N_CS];

  logic            wr, rd, pend;
  logic            ctrl_hit, shadow_hit, map_hit;
  logic            shadow_block, err_set;
  logic [N_CS-1:0] cs_hit;
  logic [31:0]     rd_value;

  assign pend    = (state == PENDING);
  assign err_irq = err;

  always_comb begin
    wr         = bus.sel & bus.wr_en;
    rd         = bus.sel & bus.rd_en;
    ctrl_hit   = (bus.addr == ADDR_W'(1));
    cs_hit     = '0;
    for (int unsigned i = 0; i < N_CS; i++)
      cs_hit[i] = (bus.addr == ADDR_W'(i + 2));
    shadow_hit   = |cs_hit;
    map_hit      = (bus.addr == '0) | ctrl_hit | shadow_hit;
    shadow_block = lock | pend;
    // Unmapped writes and blocked shadow writes both raise ERR.
    err_set      = wr & (~map_hit | (shadow_hit & shadow_block));
  end

  always_comb begin
    rd_value = '0;
    if (bus.addr == '0)
      rd_value = SMC_CONFIG;
    else if (ctrl_hit)
      rd_value = {22'b0, err, pend, 7'b0, lock};
    for (int unsigned i = 0; i < N_CS; i++)
      if (cs_hit[i])
        rd_value = shadow[i];
  end

  always_comb begin
    cs_config = '0;
    for (int unsigned i = 0; i < N_CS; i++)
      cs_config[32*i +: 32] = active[i];
  end

  always_ff @(posedge hclk) begin
    if (!n_sys_reset) begin
      state      <= IDLE;
      lock       <= 1'b0;
      err        <= 1'b0;
      cfg_update <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      for (int unsigned i = 0; i < N_CS; i++) begin
        shadow[i] <= CS_RESET;
        active[i] <= CS_RESET;
      end
    end else begin
      bus.rvalid <= rd;
      bus.rdata  <= rd ? rd_value : '0;
      cfg_update <= 1'b0;

      if (wr & ctrl_hit & bus.wdata[0])
        lock <= 1'b1;

      if (err_set)
        err <= 1'b1;
      else if (wr & ctrl_hit & bus.wdata[9])
        err <= 1'b0;

      if (wr & ~shadow_block)
        for (int unsigned i = 0; i < N_CS; i++)
          if (cs_hit[i])
            shadow[i] <= bus.wdata;

      case (state)
        IDLE: begin
          if (wr & ctrl_hit & bus.wdata[1])
            state <= PENDING;
        end
        PENDING: begin
          if (smc_idle) begin
            for (int unsigned i = 0; i < N_CS; i++)
              active[i] <= shadow[i];
            cfg_update <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smc_cfreg_bank.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against an abstract register-bank model (N_CS=4), plus N_CS=1 ID checks.
module tb_smc_cfreg_bank;

  localparam logic [31:0] RST = 32'h0000_0101;

  logic hclk = 1'b0;
  logic n_sys_reset = 1'b0;
  logic smc_idle = 1'b0;
  logic [127:0] cs4;
  logic [31:0]  cs1;
  logic upd4, upd1, err4, err1;

  smc_cfreg_bank_if #(.ADDR_W(4)) bus4 ();
  smc_cfreg_bank_if #(.ADDR_W(4)) bus1 ();

  smc_cfreg_bank #(.N_CS(4), .ADDR_W(4), .CS_RESET(RST)) u_dut4 (
    .hclk(hclk), .n_sys_reset(n_sys_reset), .bus(bus4), .smc_idle(smc_idle),
    .cs_config(cs4), .cfg_update(upd4), .err_irq(err4));

  smc_cfreg_bank #(.N_CS(1), .ADDR_W(4), .CS_RESET(RST)) u_dut1 (
    .hclk(hclk), .n_sys_reset(n_sys_reset), .bus(bus1), .smc_idle(smc_idle),
    .cs_config(cs1), .cfg_update(upd1), .err_irq(err1));

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Abstract model of the N_CS=4 bank
  logic [31:0] m_sh [4];
  logic [31:0] m_act [4];
  bit m_lock, m_pend, m_err;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 0) return 32'hC000_0004;
    if (a == 1) return {22'b0, m_err, m_pend, 7'b0, m_lock};
    if (a >= 2 && a <= 5) return m_sh[a-2];
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_sh[i] = RST; m_act[i] = RST; end
    m_lock = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic do_reset(input bit idle);
    bus4.sel = 0; bus4.wr_en = 0; bus4.rd_en = 0; bus4.addr = '0; bus4.wdata = '0;
    smc_idle = idle;
    n_sys_reset = 1'b0;
    @(posedge hclk); #1;
    n_sys_reset = 1'b1;
    m_reset();
    chk("rst_rvalid", bus4.rvalid, 0);
    chk("rst_rdata", bus4.rdata, 0);
    chk("rst_upd", upd4, 0);
    chk("rst_err", err4, 0);
    chk("rst_cs", cs4, {4{RST}});
  endtask

  task automatic cycle(input bit sel, input bit wr, input bit rd, input logic [3:0] a,
                       input logic [31:0] wd, input bit idle);
    bit e_rv, e_upd, wacc, apply_req;
    logic [31:0] e_rd;
    bus4.sel = sel; bus4.wr_en = wr; bus4.rd_en = rd; bus4.addr = a; bus4.wdata = wd;
    smc_idle = idle;
    e_rv = sel & rd;
    e_rd = e_rv ? m_read(a) : 32'h0;
    e_upd = m_pend && idle;
    wacc = sel & wr;
    apply_req = wacc && a == 1 && wd[1] && !m_pend;
    if (e_upd) for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    if (wacc) begin
      if (a > 5) m_err = 1;
      else if (a == 1) begin
        if (wd[0]) m_lock = 1;
        if (wd[9]) m_err = 0;
      end else if (a >= 2) begin
        if (m_lock || m_pend) m_err = 1;
        else m_sh[a-2] = wd;
      end
    end
    if (e_upd) m_pend = 0;
    else if (apply_req) m_pend = 1;
    @(posedge hclk); #1;
    chk("rvalid", bus4.rvalid, e_rv);
    chk("rdata", bus4.rdata, e_rd);
    chk("cfg_update", upd4, e_upd);
    chk("err_irq", err4, m_err);
    chk("cs_config", cs4, {m_act[3], m_act[2], m_act[1], m_act[0]});
  endtask

  task automatic cyc1(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd);
    bus1.sel = rd | wr; bus1.rd_en = rd; bus1.wr_en = wr; bus1.addr = a; bus1.wdata = wd;
    @(posedge hclk); #1;
    bus1.sel = 0; bus1.rd_en = 0; bus1.wr_en = 0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  a;
    logic [31:0] wd;
    bit          idle;
    bit          e_rv;
    logic [31:0] e_rd;
    bit          e_upd;
    bit          e_err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1, 0, 4'd0,  32'h0,         1, 1, 32'hC000_0004, 0, 0};
    tbl[1]  = '{1, 0, 4'd1,  32'h0,         1, 1, 32'h0,         0, 0};
    tbl[2]  = '{1, 0, 4'd2,  32'h0,         1, 1, 32'h0000_0101, 0, 0};
    tbl[3]  = '{0, 1, 4'd3,  32'h1234_5678, 1, 0, 32'h0,         0, 0};
    tbl[4]  = '{1, 0, 4'd3,  32'h0,         1, 1, 32'h1234_5678, 0, 0};
    tbl[5]  = '{1, 1, 4'd1,  32'h2,         1, 1, 32'h0,         0, 0};
    tbl[6]  = '{1, 0, 4'd1,  32'h0,         1, 1, 32'h0000_0100, 1, 0};
    tbl[7]  = '{1, 0, 4'd1,  32'h0,         1, 1, 32'h0,         0, 0};
    tbl[8]  = '{0, 1, 4'd15, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 1};
    tbl[9]  = '{1, 0, 4'd1,  32'h0,         1, 1, 32'h0000_0200, 0, 1};
    tbl[10] = '{1, 0, 4'd15, 32'h0,         1, 1, 32'h0,         0, 1};
    tbl[11] = '{1, 1, 4'd1,  32'h200,       1, 1, 32'h0000_0200, 0, 0};
    tbl[12] = '{1, 1, 4'd2,  32'hAAAA_5555, 1, 1, 32'h0000_0101, 0, 0};
    tbl[13] = '{1, 0, 4'd2,  32'h0,         1, 1, 32'hAAAA_5555, 0, 0};

    bus1.sel = 0; bus1.wr_en = 0; bus1.rd_en = 0; bus1.addr = '0; bus1.wdata = '0;
    do_reset(1'b0);

    // N_CS=1 instance: ID word, shadow reset value, unmapped access
    cyc1(1, 0, 4'd0, 32'h0);
    chk("n1_cfg_rv", bus1.rvalid, 1);
    chk("n1_cfg", bus1.rdata, 32'hC000_0001);
    cyc1(1, 0, 4'd2, 32'h0);
    chk("n1_cs0", bus1.rdata, RST);
    cyc1(1, 0, 4'd3, 32'h0);
    chk("n1_unmap_rv", bus1.rvalid, 1);
    chk("n1_unmap_rd", bus1.rdata, 0);
    chk("n1_unmap_noerr", err1, 0);
    cyc1(0, 1, 4'd15, 32'h1);
    chk("n1_unmap_err", err1, 1);
    chk("n1_rdata_idle", bus1.rdata, 0);
    chk("n1_cs_cfg", cs1, RST);

    // Directed table on the N_CS=4 instance
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rd | tbl[i].wr, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].idle);
      chk($sformatf("tbl%0d_rv", i), bus4.rvalid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_rd", i), bus4.rdata, tbl[i].e_rd);
      chk($sformatf("tbl%0d_upd", i), upd4, tbl[i].e_upd);
      chk($sformatf("tbl%0d_err", i), err4, tbl[i].e_err);
    end
    chk("tbl_cs", cs4, {RST, RST, 32'h1234_5678, RST});

    // smc_idle held low: apply stays pending, shadow writes are refused
    cycle(1, 1, 0, 4'd1, 32'h2, 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) cycle(1, 1, 0, 4'd2, 32'hDEAD_BEEF, 0);
      else        cycle(1, 0, 1, 4'd1, 32'h0, 0);
    end
    cycle(1, 0, 1, 4'd1, 32'h0, 0);
    chk("pend_ctrl", bus4.rdata, 32'h0000_0300);
    chk("pend_noupd", upd4, 0);
    cycle(0, 0, 0, 4'd0, 32'h0, 1);
    chk("pend_xfer", upd4, 1);
    chk("pend_cs0", cs4[31:0], 32'hAAAA_5555);
    cycle(1, 1, 0, 4'd1, 32'h200, 1);
    chk("err_clear", err4, 0);

    // LOCK blocks shadow writes but not APPLY, and survives a write of 0
    cycle(1, 1, 0, 4'd1, 32'h1, 1);
    cycle(1, 1, 0, 4'd2, 32'h1111_1111, 1);
    chk("lock_err", err4, 1);
    cycle(1, 0, 1, 4'd2, 32'h0, 1);
    chk("lock_sh", bus4.rdata, 32'hAAAA_5555);
    cycle(1, 1, 0, 4'd1, 32'h2, 1);
    cycle(0, 0, 0, 4'd0, 32'h0, 1);
    chk("lock_apply", upd4, 1);
    cycle(1, 1, 0, 4'd1, 32'h0, 1);
    cycle(1, 0, 1, 4'd1, 32'h0, 1);
    chk("lock_hold", bus4.rdata[0], 1);
    do_reset(1'b0);
    cycle(1, 0, 1, 4'd1, 32'h0, 1);
    chk("lock_rst", bus4.rdata, 0);

    // Reset while pending: no transfer afterwards
    cycle(1, 1, 0, 4'd4, 32'h5A5A_0000, 0);
    cycle(1, 1, 0, 4'd1, 32'h2, 0);
    cycle(0, 0, 0, 4'd0, 32'h0, 0);
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 4'd0, 32'h0, 1);
      chk("rstp_noupd", upd4, 0);
      chk("rstp_cs", cs4, {4{RST}});
    end
    cycle(1, 0, 1, 4'd1, 32'h0, 1);
    chk("rstp_ctrl", bus4.rdata, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  a;
      logic [31:0] wd;
      bit wr, rd, sel, idle;
      if ($urandom_range(0, 79) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        a    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
        wd   = $urandom;
        if (a == 1) begin
          wd[0] = ($urandom_range(0, 15) == 0);
          wd[1] = ($urandom_range(0, 2) == 0);
        end
        wr   = ($urandom_range(0, 2) == 0);
        rd   = ($urandom_range(0, 1) == 1);
        sel  = ($urandom_range(0, 7) != 0);
        idle = ($urandom_range(0, 3) != 0);
        cycle(sel, wr, rd, a, wd, idle);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smc_cfreg_bank.md
Name: smc_cfreg_bank

Overview:
- Parametrised configuration register bank for the SMC. Supersedes the fixed single read-only config word.
- Holds the read-only SMC_CONFIG identification word, a control/status register, and one 32-bit timing register per chip select.
- Each timing register is double-buffered: a software-writable shadow copy and an active copy that drives the memory controller. Shadow-to-active transfer is deferred until the controller reports idle.
- Sits between the AHB slave interface decode and the SMC timing/state machines.

Parameters:
- N_CS, 1, number of chip selects (legal range 1..8).
- ADDR_W, 4, word-address width. Must satisfy 2+N_CS <= 2**ADDR_W.
- CS_RESET, 32'h0000_0101, reset value of every shadow and active timing register.

Ports:
- hclk  input  1  system clock; all state changes on the rising edge.
- n_sys_reset  input  1  synchronous, active-low reset.
- sel  input  1  register bank selected for this access.
- wr_en  input  1  write strobe, qualified by sel.
- rd_en  input  1  read strobe, qualified by sel.
- addr  input  ADDR_W  word address.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- rvalid  output  1  rdata valid; one-cycle pulse.
- smc_idle  input  1  controller has no access in progress.
- cs_config  output  N_CS*32  active timing registers; CS n occupies bits [32n+31:32n].
- cfg_update  output  1  one-cycle pulse when active registers are loaded from the shadows.
- err_irq  output  1  equals the sticky ERR bit.

Behaviour:
Address map (word addresses):
- 0: SMC_CONFIG, RO. Value = {1'b1, 1'b1, 22'b0, N_CS[7:0]}. For N_CS=1 this is 32'hC000_0001.
- 1: CTRL. bit0 LOCK (write 1 to set; cleared only by reset). bit1 APPLY (write 1 to request; always reads 0). bit8 PEND (RO). bit9 ERR (sticky; write 1 to clear). All other bits read 0.
- 2..1+N_CS: shadow timing register for CS 0..N_CS-1, RW.
- Any other address: reads 0, writes ignored, ERR set.

Reset values (n_sys_reset low at a clock edge):
- rdata=0, rvalid=0, cfg_update=0, err_irq=0.
- LOCK=0, PEND=0, ERR=0.
- All shadow and active registers = CS_RESET.

Read path:
- sel&rd_en in cycle T gives rvalid=1 and rdata=value in cycle T+1.
- rdata returns to 0 in any cycle where rvalid=0.

Write path:
- sel&wr_en performs the write in the same edge.
- If read and write occur in the same cycle, the read returns the pre-write value.

Shadow write rules:
- LOCK=1 or PEND=1: the write is dropped and ERR is set.
- Otherwise the shadow is updated.
- Writes to CTRL are always accepted; LOCK does not block APPLY or the ERR clear.

Apply state machine, states IDLE and PENDING:
- IDLE -> PENDING on a CTRL write with bit1=1. PEND=1.
- PENDING -> IDLE on the first edge where smc_idle=1:
  - every active register <= its shadow;
  - cfg_update=1 for exactly that one cycle;
  - PEND=0.
- APPLY written while in PENDING: no effect and no error.
- APPLY write in a cycle where smc_idle=1: the transfer occurs no earlier than the next edge, so minimum latency is 1 cycle after the write.
- smc_idle stuck low: stay in PENDING indefinitely.

ERR:
- Set has priority over a simultaneous write-1-to-clear.
- err_irq is combinationally equal to ERR.

Reset mid-operation:
- Reset during PENDING returns to IDLE with active = CS_RESET. No cfg_update pulse is generated.

Width rules:
- N_CS[7:0] is zero-extended into the SMC_CONFIG field.
- addr is compared at full ADDR_W width; there is no aliasing.

Test Plan:
- Reset, then read addr 0 with N_CS=1 -> rvalid pulse one cycle later, rdata=32'hC000_0001. Read addr 1 -> 0. Read addr 2 -> 32'h0000_0101.
- N_CS=4: write 32'h1234_5678 to addr 3, smc_idle=1, then write CTRL=2 -> shadow reads back the value, PEND=1 for one cycle, cfg_update pulses, cs_config[63:32]=32'h1234_5678, other CS slices unchanged.
- Hold smc_idle=0 for 10 cycles after APPLY, write addr 2 -> write dropped, ERR=1, err_irq=1, PEND stays 1. Raise smc_idle -> transfer of the old shadows. Write CTRL=32'h200 -> ERR=0.
- Write CTRL=1 (LOCK), then write addr 2 -> shadow unchanged, ERR=1. APPLY still works. LOCK survives a write of 0 and clears only on reset.
- Access unmapped address 15 (N_CS=1) -> read returns 0 with rvalid, write sets ERR. Simultaneous read and write of addr 2 -> read returns old value.
- Assert n_sys_reset low during PENDING -> PEND=0, cs_config=CS_RESET in all slices, no cfg_update pulse after reset release even with smc_idle=1.
